// File: rtl/replica_sequencer_if.sv
// Command/status bundle between the replica sequencer and its host plus the replica array.
// The master modport is the sequencer; the slave modport is the host/replica side.
interface replica_sequencer_if;
  // start is a single-cycle request taken only while the sequencer is idle (busy low).
  // No ready is returned: done pulses once per accepted start.
  // stop is a level request that is only honoured while busy.
  logic        start;
  logic        stop;
  logic [31:0] iter_num;
  logic        busy;
  logic        done;
  logic [31:0] iter_count;
  logic        random_run;
  logic [1:0]  opt_command;
  logic [1:0]  c_distance;
  logic [1:0]  c_metropolis;
  logic [1:0]  c_exchange;
  logic        rbank;

  modport master (
    input  start, stop, iter_num,
    output busy, done, iter_count, random_run, opt_command,
           c_distance, c_metropolis, c_exchange, rbank
  );

  modport slave (
    output start, stop, iter_num,
    input  busy, done, iter_count, random_run, opt_command,
           c_distance, c_metropolis, c_exchange, rbank
  );
endinterface

// File: rtl/replica_sequencer.sv
// Per-iteration command scheduler for the replica-exchange salesman array.
// Every command output is registered and decoded from the next state, so it changes only on state boundaries.
module replica_sequencer #(
  parameter int DIST_LAT      = 4,
  parameter int CITY_NUM_LOG  = 3,
  parameter int EXCH_INTERVAL = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  replica_sequencer_if.master  seq,
  output logic [2:0]           dbg_state_o
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RAND  = 3'd1;
  localparam logic [2:0] S_DIST  = 3'd2;
  localparam logic [2:0] S_METRO = 3'd3;
  localparam logic [2:0] S_EXCH  = 3'd4;
  localparam logic [2:0] S_XREP  = 3'd5;
  localparam logic [2:0] S_SWAP  = 3'd6;
  localparam logic [2:0] S_DONE  = 3'd7;

  localparam int CW = ((CITY_NUM_LOG > $clog2(DIST_LAT)) ? CITY_NUM_LOG : $clog2(DIST_LAT)) + 1;
  localparam int IW = $clog2(EXCH_INTERVAL + 1);
  localparam logic [CW-1:0] DIST_LOAD = CW'(DIST_LAT - 1);
  localparam logic [CW-1:0] EXCH_LOAD = CW'((1 << CITY_NUM_LOG) - 1);
  localparam logic [IW-1:0] IVL_LAST  = IW'(EXCH_INTERVAL - 1);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] ivl_q, ivl_d;
  logic [31:0]   iter_tgt_q, iter_tgt_d;
  logic [31:0]   iter_count_q, iter_count_d;
  logic          phase_q, phase_d;
  logic          stop_q, stop_d;
  logic          rbank_q, rbank_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          rr_q, rr_d;
  logic [1:0]    opt_q, opt_d;
  logic [1:0]    cd_q, cd_d;
  logic [1:0]    cm_q, cm_d;
  logic [1:0]    ce_q, ce_d;
  logic          busy_now;

  assign busy_now = (state_q != S_IDLE) && (state_q != S_DONE);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ivl_d        = ivl_q;
    iter_tgt_d   = iter_tgt_q;
    iter_count_d = iter_count_q;
    phase_d      = phase_q;
    stop_d       = stop_q;
    rbank_d      = rbank_q;
    if (busy_now && seq.stop) stop_d = 1'b1;
    case (state_q)
      S_IDLE: begin
        stop_d = 1'b0;
        if (seq.start) begin
          iter_tgt_d   = seq.iter_num;
          iter_count_d = '0;
          ivl_d        = '0;
          phase_d      = 1'b0;
          state_d      = (seq.iter_num == 32'd0) ? S_DONE : S_RAND;
        end
      end
      S_RAND: begin
        state_d = S_DIST;
        cnt_d   = DIST_LOAD;
      end
      S_DIST: begin
        if (cnt_q == '0) state_d = S_METRO;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_METRO: begin
        state_d = S_EXCH;
        cnt_d   = EXCH_LOAD;
      end
      S_EXCH: begin
        if (cnt_q == '0) state_d = (ivl_q == IVL_LAST) ? S_XREP : S_SWAP;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_XREP: begin
        phase_d = ~phase_q;
        state_d = S_SWAP;
      end
      S_SWAP: begin
        rbank_d      = ~rbank_q;
        iter_count_d = iter_count_q + 32'd1;
        ivl_d        = (ivl_q == IVL_LAST) ? '0 : ivl_q + IW'(1);
        // A stop raised in this very cycle still counts as pending.
        state_d      = ((iter_count_d == iter_tgt_q) || stop_q || seq.stop) ? S_DONE : S_RAND;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);
    rr_d   = (state_d == S_RAND);
    opt_d  = busy_d ? (iter_count_d[0] ? 2'd1 : 2'd2) : 2'd0;
    cd_d   = (state_d == S_DIST) ? 2'd1 : 2'd0;
    cm_d   = 2'd0;
    ce_d   = 2'd0;
    if (state_d == S_METRO) cm_d = 2'd1;
    if (state_d == S_EXCH)  ce_d = 2'd1;
    if (state_d == S_XREP) begin
      cm_d = phase_q ? 2'd3 : 2'd2;
      ce_d = phase_q ? 2'd3 : 2'd2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      ivl_q        <= '0;
      iter_tgt_q   <= '0;
      iter_count_q <= '0;
      phase_q      <= 1'b0;
      stop_q       <= 1'b0;
      rbank_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rr_q         <= 1'b0;
      opt_q        <= 2'd0;
      cd_q         <= 2'd0;
      cm_q         <= 2'd0;
      ce_q         <= 2'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ivl_q        <= ivl_d;
      iter_tgt_q   <= iter_tgt_d;
      iter_count_q <= iter_count_d;
      phase_q      <= phase_d;
      stop_q       <= stop_d;
      rbank_q      <= rbank_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      rr_q         <= rr_d;
      opt_q        <= opt_d;
      cd_q         <= cd_d;
      cm_q         <= cm_d;
      ce_q         <= ce_d;
    end
  end

  assign seq.busy         = busy_q;
  assign seq.done         = done_q;
  assign seq.iter_count   = iter_count_q;
  assign seq.random_run   = rr_q;
  assign seq.opt_command  = opt_q;
  assign seq.c_distance   = cd_q;
  assign seq.c_metropolis = cm_q;
  assign seq.c_exchange   = ce_q;
  assign seq.rbank        = rbank_q;
  assign dbg_state_o      = state_q;
endmodule

// File: tb/tb_replica_sequencer.sv
// Bench for replica_sequencer: table-driven runs against an expected per-cycle command trace,
// plus a hand-written asynchronous-reset sequence.
`timescale 1ns/1ps
module tb_replica_sequencer;
  localparam int DIST_CYC = 4;
  localparam int EXCH_CYC = 8;

  typedef struct {
    int          sel;
    logic [31:0] iter_num;
    int          stop_cyc;
    int          restart_cyc;
    int          exp_iters;
    int          exp_busy;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_r = 1'b0;
  logic        stop_r = 1'b0;
  logic        sel = 1'b0;
  logic [31:0] iter_r = '0;
  logic [2:0]  dbg0, dbg1;
  logic [11:0] obs_w;
  logic [31:0] obs_cnt;

  int          checks = 0;
  int          failures = 0;
  logic [11:0] exp_q[$];
  logic        rb_ref[2];
  vec_t        tv[6];

  always #5 clk = ~clk;

  replica_sequencer_if if0();
  replica_sequencer_if if1();

  assign if0.start    = start_r & ~sel;
  assign if0.stop     = stop_r & ~sel;
  assign if0.iter_num = iter_r;
  assign if1.start    = start_r & sel;
  assign if1.stop     = stop_r & sel;
  assign if1.iter_num = iter_r;

  replica_sequencer #(.DIST_LAT(4), .CITY_NUM_LOG(3), .EXCH_INTERVAL(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .seq(if0.master), .dbg_state_o(dbg0)
  );
  replica_sequencer #(.DIST_LAT(4), .CITY_NUM_LOG(3), .EXCH_INTERVAL(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .seq(if1.master), .dbg_state_o(dbg1)
  );

  assign obs_w = sel ?
    {if1.busy, if1.done, if1.random_run, if1.opt_command, if1.c_distance,
     if1.c_metropolis, if1.c_exchange, if1.rbank} :
    {if0.busy, if0.done, if0.random_run, if0.opt_command, if0.c_distance,
     if0.c_metropolis, if0.c_exchange, if0.rbank};
  assign obs_cnt = sel ? if1.iter_count : if0.iter_count;

  function automatic logic [11:0] mk(logic b, logic d, logic r, logic [1:0] o,
                                     logic [1:0] cd, logic [1:0] cm, logic [1:0] ce, logic rb);
    return {b, d, r, o, cd, cm, ce, rb};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Expected trace: one word per cycle from cycle 1 after start through one idle cycle after done.
  task automatic gen(input int n, input int iv, input int s);
    logic       rb;
    logic       ph;
    logic [1:0] o;
    logic [1:0] x;
    rb = rb_ref[s];
    ph = 1'b0;
    for (int k = 0; k < n; k++) begin
      o = (k % 2 == 1) ? 2'd1 : 2'd2;
      exp_q.push_back(mk(1, 0, 1, o, 0, 0, 0, rb));
      for (int i = 0; i < DIST_CYC; i++) exp_q.push_back(mk(1, 0, 0, o, 1, 0, 0, rb));
      exp_q.push_back(mk(1, 0, 0, o, 0, 1, 0, rb));
      for (int i = 0; i < EXCH_CYC; i++) exp_q.push_back(mk(1, 0, 0, o, 0, 0, 1, rb));
      if ((k + 1) % iv == 0) begin
        x = ph ? 2'd3 : 2'd2;
        exp_q.push_back(mk(1, 0, 0, o, 0, x, x, rb));
        ph = ~ph;
      end
      exp_q.push_back(mk(1, 0, 0, o, 0, 0, 0, rb));
      rb = ~rb;
    end
    exp_q.push_back(mk(0, 1, 0, 0, 0, 0, 0, rb));
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, rb));
    rb_ref[s] = rb;
  endtask

  task automatic run_case(input int idx, input vec_t v);
    int          cyc;
    int          busy_n;
    logic [11:0] e;
    sel    = (v.sel != 0);
    iter_r = v.iter_num;
    gen(v.exp_iters, (v.sel != 0) ? 1 : 2, v.sel);
    @(negedge clk);
    start_r = 1'b1;
    cyc     = 0;
    busy_n  = 0;
    while (exp_q.size() > 0) begin
      cyc++;
      @(posedge clk);
      #1;
      start_r = (cyc == v.restart_cyc);
      stop_r  = (cyc == v.stop_cyc);
      @(negedge clk);
      e = exp_q.pop_front();
      check($sformatf("case%0d_cyc%0d", idx, cyc), 32'(obs_w), 32'(e));
      if (obs_w[11]) busy_n++;
    end
    start_r = 1'b0;
    stop_r  = 1'b0;
    check($sformatf("case%0d_iter_count", idx), obs_cnt, 32'(v.exp_iters));
    check($sformatf("case%0d_busy_cycles", idx), 32'(busy_n), 32'(v.exp_busy));
  endtask

  initial begin
    int rn;
    rb_ref[0] = 1'b0;
    rb_ref[1] = 1'b0;
    rn = int'($urandom_range(1, 5));
    tv[0] = '{0, 32'd2,   0,  0,  2, 31};
    tv[1] = '{0, 32'd4,   0,  0,  4, 62};
    tv[2] = '{0, 32'd0,   0,  0,  0, 0};
    tv[3] = '{0, 32'd100, 34, 0,  3, 46};
    tv[4] = '{1, 32'd3,   0,  10, 3, 48};
    tv[5] = '{0, 32'(rn), 0,  int'($urandom_range(5, 12)), rn, 15 * rn + rn / 2};

    #2;
    check("reset_outputs", 32'(obs_w), 32'd0);
    check("reset_iter_count", obs_cnt, 32'd0);
    check("reset_state", 32'(dbg0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_case(i, tv[i]);

    // Asynchronous reset in the middle of iteration 2's ordering update.
    sel    = 1'b0;
    iter_r = 32'd4;
    @(negedge clk);
    start_r = 1'b1;
    @(posedge clk);
    #1;
    start_r = 1'b0;
    repeat (24) @(posedge clk);
    @(negedge clk);
    check("pre_reset_c_exchange", 32'(if0.c_exchange), 32'd1);
    check("pre_reset_iter_count", obs_cnt, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", 32'(obs_w), 32'd0);
    check("async_reset_iter_count", obs_cnt, 32'd0);
    check("async_reset_state", 32'(dbg0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rb_ref[0] = 1'b0;
    rb_ref[1] = 1'b0;
    run_case(6, '{0, 32'd1, 0, 0, 1, 15});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/replica_sequencer.md
# replica_sequencer

Per-iteration command scheduler for the replica-exchange salesman array. One instance drives the shared command buses of all `replica` instances: random-number advance, opt-move selection, delta-distance calculation, Metropolis judgement, ordering update, periodic replica exchange and bank swap. It runs a programmed number of annealing iterations from a single `start` pulse and reports completion.

## Interface
Parameters:
- `DIST_LAT`, 4: cycles `c_distance` stays in CALC (distance datapath latency).
- `CITY_NUM_LOG`, 3: log2 of city count; the ordering update lasts 2^CITY_NUM_LOG cycles.
- `EXCH_INTERVAL`, 2: a replica exchange runs after every EXCH_INTERVAL-th iteration (≥1).

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin run; sampled only in IDLE.
- `stop`  in  1  request early finish; level, sampled any cycle while busy.
- `iter_num`  in  32  iterations to run; latched at start.
- `busy`  out  1  high from the cycle after start until the last SWAP cycle.
- `done`  out  1  one-cycle pulse in the DONE state.
- `iter_count`  out  32  completed iterations in the current/last run.
- `random_run`  out  1  advance random generators (RAND state).
- `opt_command`  out  2  0 NONE, 1 OR_OPT, 2 TWO_OPT.
- `c_distance`  out  2  0 NOP, 1 CALC.
- `c_metropolis`  out  2  0 NOP, 1 JUDGE, 2 RX_EVEN, 3 RX_ODD.
- `c_exchange`  out  2  0 NOP, 1 OPT, 2 RX_EVEN, 3 RX_ODD.
- `rbank`  out  1  ordering read bank; toggles every SWAP.

## Operation
- States: IDLE, RAND, DIST, METRO, EXCH, XREP, SWAP, DONE.
- IDLE: all command outputs 0. `start`=1 latches `iter_num`, clears `iter_count` and the exchange-phase flag (even); → DONE if iter_num=0, else → RAND.
- RAND (1 cycle): `random_run`=1. → DIST.
- DIST (DIST_LAT cycles, down-counter): `c_distance`=CALC. → METRO.
- METRO (1 cycle): `c_metropolis`=JUDGE. → EXCH.
- EXCH (2^CITY_NUM_LOG cycles): `c_exchange`=OPT. → XREP if (iter_count+1) mod EXCH_INTERVAL = 0, else → SWAP.
- XREP (1 cycle): `c_metropolis` and `c_exchange` = RX_EVEN if phase even, RX_ODD if odd; phase toggles on exit. → SWAP.
- SWAP (1 cycle): `rbank` toggles at the cycle end, `iter_count`+1. → DONE if iter_count+1 = latched iter_num or a stop was pending, else → RAND.
- DONE (1 cycle): `done`=1, `busy`=0. → IDLE.
- `opt_command` is held stable RAND through SWAP: TWO_OPT when iter_count[0]=0, OR_OPT when 1; NONE in IDLE/DONE.
- `stop` sets a sticky pending flag; the current iteration always completes (commands are never cut mid-phase); flag cleared in IDLE.
- `start` while busy is ignored. `iter_count` holds its final value after DONE until the next start.
- Counter widths: phase counter max(CITY_NUM_LOG, clog2(DIST_LAT))+1 bits; interval counter clog2(EXCH_INTERVAL+1) bits, reset to 0 on start, wraps to 0 at EXCH_INTERVAL.

## Timing
- Reset (asserted low, asynchronous): state IDLE, all outputs 0, `rbank`=0, `iter_count`=0, phase even, stop flag clear; takes effect mid-iteration without completing it.
- All outputs registered; command outputs change only on state boundaries.
- Cycles per iteration: 3 + DIST_LAT + 2^CITY_NUM_LOG, plus 1 when XREP runs.
- Latency: start sampled at edge 0 → RAND (busy=1) in cycle 1; done pulse in the cycle after the final SWAP.
- `rbank` toggles exactly once per iteration; after N iterations, rbank = N mod 2 (relative to start value).

## Test plan
- Defaults, iter_num=2: RAND at cycle 1, CALC cycles 2–5, JUDGE 6, OPT 7–14, SWAP 15; iter 2 RAND 16 … OPT 22–29, XREP RX_EVEN 30, SWAP 31, done cycle 32; iter_count=2, rbank=0.
- iter_num=4: XREP in iterations 2 and 4 with RX_EVEN then RX_ODD; opt_command TWO_OPT, OR_OPT, TWO_OPT, OR_OPT; total busy 62 cycles.
- iter_num=0: done one cycle after start, no command asserted, busy never high.
- iter_num=100, stop pulsed during DIST of iteration 3: iteration 3 finishes, done after its SWAP, iter_count=3.
- Reset low during EXCH of iteration 2: all outputs 0 immediately; subsequent start with iter_num=1 runs cleanly, done with iter_count=1.
- start re-pulsed while busy and EXCH_INTERVAL=1: ignored; XREP every iteration, phase alternating.
